// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// The data side has priority. A saturating streak counter bounds fetch starvation.
module mem_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | sample requests, grant one side
  // BUSY_I | fetch read in flight, waiting for mem_ack
  // BUSY_D | data read/write in flight, waiting for mem_ack
  // RESP_I | i_ack pulse, no grant this cycle
  // RESP_D | d_ack pulse, no grant this cycle
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  localparam logic [2:0] MAX_STREAK = 3'(MAX_D_STREAK);

  state_t               state, state_nxt;
  logic [2:0]           streak, streak_nxt;
  logic                 rd_nxt, wr_nxt;
  logic [WORD_SIZE-1:0] addr_nxt, wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic                 grant_d, grant_i;

  assign grant_d = d_req && (!i_req || (streak < MAX_STREAK));
  assign grant_i = i_req && !grant_d;

  assign i_ack = (state == RESP_I);
  assign d_ack = (state == RESP_D);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      streak      <= 3'd0;
      mem_readM   <= 1'b0;
      mem_writeM  <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
    end else begin
      state       <= state_nxt;
      streak      <= streak_nxt;
      mem_readM   <= rd_nxt;
      mem_writeM  <= wr_nxt;
      mem_address <= addr_nxt;
      mem_wdata   <= wdata_nxt;
      i_rdata     <= i_rdata_nxt;
      d_rdata     <= d_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    streak_nxt  = streak;
    rd_nxt      = mem_readM;
    wr_nxt      = mem_writeM;
    addr_nxt    = mem_address;
    wdata_nxt   = mem_wdata;
    i_rdata_nxt = i_rdata;
    d_rdata_nxt = d_rdata;
    case (state)
      IDLE: begin
        if (!i_req) streak_nxt = 3'd0;
        if (grant_d) begin
          state_nxt = BUSY_D;
          addr_nxt  = d_address;
          wdata_nxt = d_wdata;
          rd_nxt    = !d_we;
          wr_nxt    = d_we;
          // Only D grants that make a pending fetch wait count toward the streak.
          if (i_req && (streak != MAX_STREAK)) streak_nxt = streak + 3'd1;
        end else if (grant_i) begin
          state_nxt  = BUSY_I;
          addr_nxt   = i_address;
          rd_nxt     = 1'b1;
          wr_nxt     = 1'b0;
          streak_nxt = 3'd0;
        end
      end
      BUSY_I: begin
        if (mem_ack) begin
          state_nxt   = RESP_I;
          rd_nxt      = 1'b0;
          wr_nxt      = 1'b0;
          i_rdata_nxt = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_nxt = RESP_D;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          if (mem_readM) d_rdata_nxt = mem_rdata;
        end
      end
      RESP_I, RESP_D: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule
